// File: rtl/fir_pkg.sv
// Shared FIR defaults and coefficient-loader state encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package fir_pkg;

    localparam int COEFF_SIZE_DEF  = 64;
    localparam int INPUT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } loader_state_t;

    function automatic logic state_busy(loader_state_t s);
        return (s == ST_LOAD_HI) || (s == ST_LOAD_LO) || (s == ST_WRITE);
    endfunction

    // DONE keeps accepting so late bytes are drained and flagged, not stalled.
    function automatic logic state_byte_ready(loader_state_t s);
        return (s == ST_LOAD_HI) || (s == ST_LOAD_LO) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/coeff_loader_if.sv
// Byte stream from the UART receive side into the coefficient loader.
// Transfer happens on byte_valid && byte_ready; the loader stalls the source by dropping byte_ready.
interface coeff_loader_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input  byte_ready);
    modport slave  (input  byte_valid, input  byte_data, output byte_ready);

endinterface

// File: rtl/coeff_ram.sv
// Simple dual-port coefficient store: one synchronous write port, one synchronous read port.
// Read latency 1 cycle, read-first on address collision; no backpressure, always ready.
module coeff_ram #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = $signed(rd_data_q);

endmodule

// File: rtl/coeff_loader.sv
// Assembles big-endian byte pairs into coefficient words and writes them to coeff_ram.
// 3 cycles minimum per word (hi, lo, write); read port has 1-cycle latency.
// byte_ready drops in IDLE and during the write cycle; input stalls hold the load states.
module coeff_loader
    import fir_pkg::*;
#(
    parameter  int COEFF_SIZE  = COEFF_SIZE_DEF,
    parameter  int INPUT_WIDTH = INPUT_WIDTH_DEF,
    localparam int ADDR_W      = $clog2(COEFF_SIZE)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    coeff_loader_if.slave                 byte_if,
    input  logic [ADDR_W-1:0]             rd_address,
    output logic signed [INPUT_WIDTH-1:0] rd_data,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W:0]               coeff_count,
    output logic                          overflow_err
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(COEFF_SIZE - 1);

    loader_state_t   state_d, state_q;
    logic [ADDR_W:0] waddr_d, waddr_q;
    logic [ADDR_W:0] coeff_count_d, coeff_count_q;
    logic [7:0]      hi_d, hi_q;
    logic [7:0]      lo_d, lo_q;
    logic            overflow_err_d, overflow_err_q;
    logic            wr_en;
    logic            accept;

    assign byte_if.byte_ready = state_byte_ready(state_q);
    assign accept             = byte_if.byte_valid && byte_if.byte_ready;

    always_comb begin
        state_d        = state_q;
        waddr_d        = waddr_q;
        coeff_count_d  = coeff_count_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        overflow_err_d = overflow_err_q;
        wr_en          = 1'b0;

        // start outranks everything, including a pending write or a byte in flight.
        if (start) begin
            state_d        = ST_LOAD_HI;
            waddr_d        = '0;
            coeff_count_d  = '0;
            hi_d           = '0;
            lo_d           = '0;
            overflow_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_LOAD_HI: begin
                    if (accept) begin
                        hi_d    = byte_if.byte_data;
                        state_d = ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    if (accept) begin
                        lo_d    = byte_if.byte_data;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wr_en         = 1'b1;
                    waddr_d       = waddr_q + 1'b1;
                    coeff_count_d = coeff_count_q + 1'b1;
                    state_d       = (waddr_q == LAST_ADDR) ? ST_DONE : ST_LOAD_HI;
                end
                ST_DONE: begin
                    if (accept) begin
                        overflow_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            waddr_q        <= '0;
            coeff_count_q  <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            waddr_q        <= waddr_d;
            coeff_count_q  <= coeff_count_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign busy         = state_busy(state_q);
    assign done         = (state_q == ST_DONE);
    assign coeff_count  = coeff_count_q;
    assign overflow_err = overflow_err_q;

    coeff_ram #(
        .DEPTH (COEFF_SIZE),
        .WIDTH (INPUT_WIDTH)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (waddr_q[ADDR_W-1:0]),
        .wr_data (INPUT_WIDTH'({hi_q, lo_q})),
        .rd_addr (rd_address),
        .rd_data (rd_data)
    );

endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 Parameter COEFF_SIZE, default 64: number of coefficients stored.
REQ-002 Parameter INPUT_WIDTH, default 16: coefficient width; only 16 is supported, as two bytes per word.
REQ-003 Localparam ADDR_W = clog2(COEFF_SIZE).
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse that begins or restarts a load session at address 0.
REQ-007 byte_valid  in  1  an incoming byte (UART receive side) is present.
REQ-008 byte_data  in  8  incoming byte.
REQ-009 byte_ready  out  1  loader accepts byte_data this cycle.
REQ-010 rd_address  in  ADDR_W  filter-side read address.
REQ-011 rd_data  out  INPUT_WIDTH, signed  coefficient at the registered rd_address.
REQ-012 busy  out  1  a load session is in progress.
REQ-013 done  out  1  all COEFF_SIZE words written; sticky until the next start or reset.
REQ-014 coeff_count  out  ADDR_W+1  number of words written in the current session.
REQ-015 overflow_err  out  1  sticky: a byte was received after done.

Function
REQ-016 A byte transfers only on a cycle where byte_valid and byte_ready are both 1; byte_data is ignored otherwise.
REQ-017 The FSM has five states: IDLE, LOAD_HI, LOAD_LO, WRITE and DONE.
REQ-018 byte_ready is 1 in LOAD_HI, LOAD_LO and DONE, and 0 in IDLE and WRITE.
REQ-019 IDLE: start moves the FSM to LOAD_HI; waddr and coeff_count clear to 0; done and overflow_err clear.
REQ-020 LOAD_HI: an accepted byte is latched as word[15:8] and the FSM moves to LOAD_LO.
REQ-021 LOAD_LO: an accepted byte is latched as word[7:0] and the FSM moves to WRITE.
REQ-022 WRITE lasts exactly one cycle: mem[waddr] takes {hi,lo}, coeff_count increments, and waddr increments.
REQ-023 On leaving WRITE, the FSM moves to DONE if waddr was COEFF_SIZE-1, and to LOAD_HI otherwise.
REQ-024 Word order is big-endian (high byte first).
REQ-025 Minimum load latency is 3 cycles per word; input stalls (byte_valid=0) extend LOAD_HI and LOAD_LO indefinitely.
REQ-026 DONE: done=1 and busy=0; each accepted byte is discarded and sets overflow_err.
REQ-027 busy is 1 in the LOAD_HI, LOAD_LO and WRITE states.
REQ-028 A start in any state aborts the session and re-enters LOAD_HI with counters and flags cleared, exactly as from IDLE.
REQ-029 A start during WRITE has priority: that cycle's memory write is suppressed.
REQ-030 A start coincident with an accepted byte drops the byte.
REQ-031 Read path: rd_data updates on the rising edge to mem[rd_address], giving 1-cycle latency; this is independent of the FSM.
REQ-032 A read and a write to the same address in the same cycle return the old contents (read-first).
REQ-033 waddr never wraps; writes occur only for addresses 0..COEFF_SIZE-1.

Reset
REQ-034 reset_n low asynchronously forces the FSM to IDLE and clears waddr, coeff_count, hi/lo latches, done, overflow_err, busy, byte_ready and rd_data.
REQ-035 Memory contents are not cleared by reset.
REQ-036 Reset asserted mid-session abandons the session; partially written words remain in memory.

Structure
REQ-037 A shared package fir_pkg holds the COEFF_SIZE and INPUT_WIDTH defaults and the loader state encoding.
REQ-038 Storage is a sub-module, coeff_ram: simple dual-port, one synchronous write port and one synchronous read port.
REQ-039 coeff_loader contains the FSM, byte assembly and counters only.

Verification
REQ-040 Full load: reset, pulse start, stream 128 bytes 0x00,0x00,0x00,0x01,...; expect done=1, coeff_count=64, mem[k]=k, busy=0.
REQ-041 Readback: after the full load, rd_address=5 -> rd_data=5 on the next edge; set word 63=0xFFFF -> rd_data reads -1 signed.
REQ-042 Backpressure: bytes 0x12 then 0x34 with byte_valid gaps of 4 cycles -> mem[0]=0x1234, byte_ready=0 during WRITE, no byte lost.
REQ-043 Overflow: after done, send byte 0xAA -> overflow_err=1, memory unchanged, done stays 1; a new start clears both flags.
REQ-044 Restart: start after 10 words, then 128 new bytes -> coeff_count restarts at 0; start asserted during WRITE suppresses that write.
REQ-045 Async reset: reset_n low mid-LOAD_LO -> all outputs 0 immediately; previously written words are retained and readable.
